// File: rtl/stopwatch_pkg.sv
// Shared field widths and limits for the stopwatch time registers.
package stopwatch_pkg;

    localparam int MSEC_W = 7;
    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    localparam logic [MSEC_W-1:0] MSEC_MAX = 7'd99;
    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

endpackage

// File: rtl/stopwatch_datapath_tick_gen.sv
// Prescaler: counts 0..TICK_DIV-1 while enabled and pulses tick on the wrap edge.
module tick_gen #(
    parameter int TICK_DIV = 1_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    // Clear wins, so a coincident terminal count never produces a tick.
    assign tick = enable & ~clear & (r_cnt == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/stopwatch_datapath.sv
// Up/down stopwatch time registers driven by a prescaled 10 ms tick.
// Define STOPWATCH_HOUR_EN to build the hour counter; otherwise o_hour is tied to 0.
module stopwatch_datapath
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 1_000_000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_run_stop,
    input  logic              i_clear,
    input  logic              i_mode,
    output logic [MSEC_W-1:0] o_msec,
    output logic [SEC_W-1:0]  o_sec,
    output logic [MIN_W-1:0]  o_min,
    output logic [HOUR_W-1:0] o_hour,
    output logic              o_tick
);

    logic              w_tick;
    logic [MSEC_W-1:0] r_msec, w_msec_nxt;
    logic [SEC_W-1:0]  r_sec,  w_sec_nxt;
    logic [MIN_W-1:0]  r_min,  w_min_nxt;
    logic              r_tick;
    logic              w_ms_end, w_sec_end, w_min_end;
    logic              w_sec_adv, w_min_adv;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (i_run_stop),
        .clear   (i_clear),
        .tick    (w_tick)
    );

    // "end" means the field is at its wrap point for the current direction.
    always_comb begin
        w_ms_end  = i_mode ? (r_msec == '0) : (r_msec == MSEC_MAX);
        w_sec_end = i_mode ? (r_sec  == '0) : (r_sec  == SEC_MAX);
        w_min_end = i_mode ? (r_min  == '0) : (r_min  == MIN_MAX);
        w_sec_adv = w_ms_end;
        w_min_adv = w_ms_end & w_sec_end;

        w_msec_nxt = w_ms_end ? (i_mode ? MSEC_MAX : '0)
                              : (i_mode ? r_msec - 1'b1 : r_msec + 1'b1);
        w_sec_nxt  = r_sec;
        if (w_sec_adv)
            w_sec_nxt = w_sec_end ? (i_mode ? SEC_MAX : '0)
                                  : (i_mode ? r_sec - 1'b1 : r_sec + 1'b1);
        w_min_nxt  = r_min;
        if (w_min_adv)
            w_min_nxt = w_min_end ? (i_mode ? MIN_MAX : '0)
                                  : (i_mode ? r_min - 1'b1 : r_min + 1'b1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_msec <= '0;
            r_sec  <= '0;
            r_min  <= '0;
            r_tick <= 1'b0;
        end else if (i_clear) begin
            r_msec <= '0;
            r_sec  <= '0;
            r_min  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_tick;
            if (w_tick) begin
                r_msec <= w_msec_nxt;
                r_sec  <= w_sec_nxt;
                r_min  <= w_min_nxt;
            end
        end
    end

`ifdef STOPWATCH_HOUR_EN
    logic [HOUR_W-1:0] r_hour, w_hour_nxt;
    logic              w_hour_adv;

    always_comb begin
        w_hour_adv = w_min_adv & w_min_end;
        w_hour_nxt = r_hour;
        if (w_hour_adv) begin
            if (i_mode)
                w_hour_nxt = (r_hour == '0) ? HOUR_MAX : r_hour - 1'b1;
            else
                w_hour_nxt = (r_hour == HOUR_MAX) ? '0 : r_hour + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_hour <= '0;
        else if (i_clear)
            r_hour <= '0;
        else if (w_tick)
            r_hour <= w_hour_nxt;
    end

    assign o_hour = r_hour;
`else
    assign o_hour = '0;
`endif

    assign o_msec = r_msec;
    assign o_sec  = r_sec;
    assign o_min  = r_min;
    assign o_tick = r_tick;

endmodule

// File: tb/tb_stopwatch_datapath.sv
// Directed bench for stopwatch_datapath at TICK_DIV=4: vector table plus corner sequences.
module tb_stopwatch_datapath;

    localparam int TD = 4;
`ifdef STOPWATCH_HOUR_EN
    localparam int HTOP = 23;
`else
    localparam int HTOP = 0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       i_run_stop = 1'b0;
    logic       i_clear = 1'b0;
    logic       i_mode = 1'b0;
    logic [6:0] o_msec;
    logic [5:0] o_sec;
    logic [5:0] o_min;
    logic [4:0] o_hour;
    logic       o_tick;

    int n_checks = 0;
    int n_fail   = 0;

    stopwatch_datapath #(.TICK_DIV(TD)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_run_stop (i_run_stop),
        .i_clear    (i_clear),
        .i_mode     (i_mode),
        .o_msec     (o_msec),
        .o_sec      (o_sec),
        .o_min      (o_min),
        .o_hour     (o_hour),
        .o_tick     (o_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        string nm;
        bit    run;
        bit    clr;
        bit    mode;
        int    cyc;
        int    h, m, s, ms;
        bit    tk;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_time(input string nm, input int h, input int m, input int s, input int ms);
        check({nm, ".hour"}, 32'(o_hour), h);
        check({nm, ".min"},  32'(o_min),  m);
        check({nm, ".sec"},  32'(o_sec),  s);
        check({nm, ".msec"}, 32'(o_msec), ms);
    endtask

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"clear",     0, 1, 0,  1, 0,    0,  0,  0, 0};
        vecs[1] = '{"down_wrap", 1, 0, 1,  4, HTOP, 59, 59, 99, 1};
        vecs[2] = '{"down_step", 1, 0, 1,  4, HTOP, 59, 59, 98, 1};
        vecs[3] = '{"up_step",   1, 0, 0,  4, HTOP, 59, 59, 99, 1};
        vecs[4] = '{"up_wrap",   1, 0, 0,  4, 0,    0,  0,  0, 1};
        vecs[5] = '{"up_two",    1, 0, 0,  8, 0,    0,  0,  2, 1};
        vecs[6] = '{"hold",      0, 0, 0, 10, 0,    0,  0,  2, 0};
        vecs[7] = '{"down_one",  1, 0, 1,  4, 0,    0,  0,  1, 1};
        vecs[8] = '{"down_zero", 1, 0, 1,  4, 0,    0,  0,  0, 1};

        // Reset state
        #3;
        chk_time("reset", 0, 0, 0, 0);
        check("reset.tick", 32'(o_tick), 0);
        step(2);
        reset_n = 1'b1;
        step(1);

        // Free run up: tick every TD cycles, 100 ticks -> 1.00 s
        i_run_stop = 1'b1;
        i_mode     = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            step(1);
            check($sformatf("cadence.k%0d", k), 32'(o_tick), (k % TD == 0) ? 1 : 0);
        end
        chk_time("run400", 0, 0, 1, 0);

        // Table
        for (int i = 0; i < 9; i++) begin
            i_run_stop = vecs[i].run;
            i_clear    = vecs[i].clr;
            i_mode     = vecs[i].mode;
            step(vecs[i].cyc);
            chk_time(vecs[i].nm, vecs[i].h, vecs[i].m, vecs[i].s, vecs[i].ms);
            check({vecs[i].nm, ".tick"}, 32'(o_tick), 32'(vecs[i].tk));
        end

        // Hold mid-prescaler, then resume
        i_run_stop = 1'b0; i_clear = 1'b1; i_mode = 1'b0;
        step(1);
        i_clear = 1'b0; i_run_stop = 1'b1;
        step(2);
        check("pause.pre_tick", 32'(o_tick), 0);
        i_run_stop = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            check("pause.hold_tick", 32'(o_tick), 0);
            check("pause.hold_msec", 32'(o_msec), 0);
        end
        i_run_stop = 1'b1;
        step(1);
        check("resume.edge1_tick", 32'(o_tick), 0);
        step(1);
        check("resume.edge2_tick", 32'(o_tick), 1);
        chk_time("resume", 0, 0, 0, 1);

        // Clear coincident with a tick at 00:00:05.37
        i_run_stop = 1'b0; i_clear = 1'b1;
        step(1);
        i_clear = 1'b0; i_run_stop = 1'b1;
        step(537 * TD);
        chk_time("preclr", 0, 0, 5, 37);
        step(TD - 1);
        check("preclr.tick", 32'(o_tick), 0);
        i_clear = 1'b1;
        step(1);
        chk_time("clr_tick", 0, 0, 0, 0);
        check("clr_tick.tick", 32'(o_tick), 0);
        i_clear = 1'b0;
        for (int k = 1; k <= TD; k++) begin
            step(1);
            check($sformatf("postclr.k%0d", k), 32'(o_tick), (k == TD) ? 1 : 0);
        end
        chk_time("postclr", 0, 0, 0, 1);

        // Async reset mid-cycle while o_tick is high
        #3;
        reset_n = 1'b0;
        #1;
        chk_time("areset", 0, 0, 0, 0);
        check("areset.tick", 32'(o_tick), 0);
        step(1);
        chk_time("areset_hold", 0, 0, 0, 0);
        #3;
        reset_n = 1'b1;
        for (int k = 1; k <= TD; k++) begin
            step(1);
            check($sformatf("postrst.k%0d", k), 32'(o_tick), (k == TD) ? 1 : 0);
        end
        chk_time("postrst", 0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
